// File: rtl/vip_binary_stream_gen_if.sv
// 1-bit VIP pixel stream bundle: frame/line/pixel strobes plus the binary pixel.
// The generator drives it through master; consumers such as the 3x3 matrix use slave.
interface vip_binary_stream_gen_if;
   logic per_frame_vsync;
   logic per_frame_href;
   logic per_frame_clken;
   logic per_img_Y;

   modport master (
      output per_frame_vsync,
      output per_frame_href,
      output per_frame_clken,
      output per_img_Y
   );

   modport slave (
      input per_frame_vsync,
      input per_frame_href,
      input per_frame_clken,
      input per_img_Y
   );
endinterface

// File: rtl/vip_binary_stream_gen.sv
// Source of a 1-bit VIP pixel stream with programmable geometry, blanking and pacing.
// Every stream output is registered from the next-state values, so outputs never glitch.
module vip_binary_stream_gen #(
   parameter logic [9:0] IMG_HDISP = 10'd480,
   parameter logic [9:0] IMG_VDISP = 10'd272,
   parameter logic [9:0] H_BLANK   = 10'd16,
   parameter logic [9:0] V_LEAD    = 10'd4,
   parameter logic [9:0] V_BLANK   = 10'd32,
   parameter logic [3:0] CLKEN_DIV = 4'd1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        continuous,
   input  logic [1:0]                  pattern_sel,
   vip_binary_stream_gen_if.master     vip,
   output logic                        busy,
   output logic                        frame_done,
   output logic [15:0]                 frame_cnt
);

   typedef enum logic [2:0] {S_IDLE, S_LEAD, S_ACTIVE, S_HBLK, S_VBLK} state_t;

   state_t     state_q, state_d;
   logic [9:0] cnt_q, cnt_d;
   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic [3:0] div_q, div_d;
   logic [1:0] pat_q, pat_d;
   logic       vblk_entry;

   function automatic logic pixel(input logic [1:0] pat, input logic [9:0] x, input logic [9:0] y);
      logic v;
      case (pat)
         2'd1:    v = x[0] ^ y[0];
         2'd2:    v = x[3];
         2'd3:    v = (x == 10'd0) || (x == IMG_HDISP - 10'd1) ||
                      (y == 10'd0) || (y == IMG_VDISP - 10'd1);
         default: v = 1'b0;
      endcase
      return v;
   endfunction

   // NOTE: every next-state variable is defaulted first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      div_d   = div_q;
      pat_d   = pat_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LEAD;
               cnt_d   = 10'd0;
               x_d     = 10'd0;
               y_d     = 10'd0;
               div_d   = 4'd0;
               pat_d   = pattern_sel;
            end
         end
         S_LEAD: begin
            if (cnt_q == V_LEAD - 10'd1) begin
               state_d = S_ACTIVE;
               cnt_d   = 10'd0;
               x_d     = 10'd0;
               div_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 10'd1;
            end
         end
         S_ACTIVE: begin
            // div paces the slot; x only moves on the last clock of a slot
            if (div_q == CLKEN_DIV - 4'd1) begin
               div_d = 4'd0;
               if (x_q == IMG_HDISP - 10'd1) begin
                  state_d = S_HBLK;
                  cnt_d   = 10'd0;
               end else begin
                  x_d = x_q + 10'd1;
               end
            end else begin
               div_d = div_q + 4'd1;
            end
         end
         S_HBLK: begin
            if (cnt_q == H_BLANK - 10'd1) begin
               cnt_d = 10'd0;
               x_d   = 10'd0;
               div_d = 4'd0;
               if (y_q == IMG_VDISP - 10'd1) begin
                  state_d = S_VBLK;
                  y_d     = 10'd0;
               end else begin
                  state_d = S_ACTIVE;
                  y_d     = y_q + 10'd1;
               end
            end else begin
               cnt_d = cnt_q + 10'd1;
            end
         end
         S_VBLK: begin
            if (cnt_q == V_BLANK - 10'd1) begin
               cnt_d = 10'd0;
               if (continuous) begin
                  state_d = S_LEAD;
                  pat_d   = pattern_sel;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 10'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign vblk_entry = (state_q == S_HBLK) && (state_d == S_VBLK);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q             <= S_IDLE;
         cnt_q               <= 10'd0;
         x_q                 <= 10'd0;
         y_q                 <= 10'd0;
         div_q               <= 4'd0;
         pat_q               <= 2'd0;
         vip.per_frame_vsync <= 1'b0;
         vip.per_frame_href  <= 1'b0;
         vip.per_frame_clken <= 1'b0;
         vip.per_img_Y       <= 1'b0;
         busy                <= 1'b0;
         frame_done          <= 1'b0;
         frame_cnt           <= 16'd0;
      end else begin
         state_q             <= state_d;
         cnt_q               <= cnt_d;
         x_q                 <= x_d;
         y_q                 <= y_d;
         div_q               <= div_d;
         pat_q               <= pat_d;
         vip.per_frame_vsync <= state_d inside {S_LEAD, S_ACTIVE, S_HBLK};
         vip.per_frame_href  <= (state_d == S_ACTIVE);
         vip.per_frame_clken <= (state_d == S_ACTIVE) && (div_d == 4'd0);
         vip.per_img_Y       <= (state_d == S_ACTIVE) && pixel(pat_d, x_d, y_d);
         busy                <= (state_d != S_IDLE);
         frame_done          <= vblk_entry;
         if (vblk_entry) frame_cnt <= frame_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_vip_binary_stream_gen.sv
// Bench for vip_binary_stream_gen: two instances (1 and 2 clocks per pixel) checked every cycle
// against a frame-position model, plus literal expectations for the small test geometry.
module tb_vip_binary_stream_gen;

   localparam int H  = 4;
   localparam int V  = 3;
   localparam int HB = 2;
   localparam int VL = 1;
   localparam int VB = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        continuous = 1'b0;
   logic [1:0]  pattern_sel = 2'd0;
   logic        busy0, busy1, frame_done0, frame_done1;
   logic [15:0] frame_cnt0, frame_cnt1;

   int total = 0;
   int bad   = 0;

   vip_binary_stream_gen_if vif0 ();
   vip_binary_stream_gen_if vif1 ();

   vip_binary_stream_gen #(
      .IMG_HDISP(10'd4), .IMG_VDISP(10'd3), .H_BLANK(10'd2),
      .V_LEAD(10'd1), .V_BLANK(10'd3), .CLKEN_DIV(4'd1)
   ) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous),
      .pattern_sel(pattern_sel), .vip(vif0), .busy(busy0),
      .frame_done(frame_done0), .frame_cnt(frame_cnt0)
   );

   vip_binary_stream_gen #(
      .IMG_HDISP(10'd4), .IMG_VDISP(10'd3), .H_BLANK(10'd2),
      .V_LEAD(10'd1), .V_BLANK(10'd3), .CLKEN_DIV(4'd2)
   ) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous),
      .pattern_sel(pattern_sel), .vip(vif1), .busy(busy1),
      .frame_done(frame_done1), .frame_cnt(frame_cnt1)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model: position within the frame timeline ----------------
   bit          m_act [2] = '{0, 0};
   int          m_p   [2] = '{0, 0};
   logic [1:0]  m_pat [2] = '{2'd0, 2'd0};
   logic [15:0] m_fc  [2] = '{16'd0, 16'd0};
   bit          last_rst = 1'b1;

   function automatic int line_len(input int d);
      return H * (d + 1) + HB;
   endfunction

   function automatic int frame_len(input int d);
      return VL + V * line_len(d) + VB;
   endfunction

   function automatic logic pix(input logic [1:0] pat, input int x, input int y);
      case (pat)
         2'd1:    return logic'(((x + y) % 2) == 1);
         2'd2:    return logic'(((x / 8) % 2) == 1);
         2'd3:    return logic'(x == 0 || x == H - 1 || y == 0 || y == V - 1);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] model_out(input int d);
      int div, ll, q, line, r;
      logic vs, hr, ce, yy, bz, dn;
      vs = 0; hr = 0; ce = 0; yy = 0; bz = 0; dn = 0;
      if (m_act[d]) begin
         bz  = 1;
         div = d + 1;
         ll  = line_len(d);
         if (m_p[d] < VL) begin
            vs = 1;
         end else begin
            q    = m_p[d] - VL;
            line = q / ll;
            r    = q % ll;
            if (line < V) begin
               vs = 1;
               if (r < H * div) begin
                  hr = 1;
                  ce = logic'((r % div) == 0);
                  yy = pix(m_pat[d], r / div, line);
               end
            end else begin
               dn = logic'(q == V * ll);
            end
         end
      end
      return {10'd0, vs, hr, ce, yy, bz, dn, m_fc[d]};
   endfunction

   function automatic logic [31:0] dut_out(input int d);
      if (d == 0)
         return {10'd0, vif0.per_frame_vsync, vif0.per_frame_href, vif0.per_frame_clken,
                 vif0.per_img_Y, busy0, frame_done0, frame_cnt0};
      return {10'd0, vif1.per_frame_vsync, vif1.per_frame_href, vif1.per_frame_clken,
              vif1.per_img_Y, busy1, frame_done1, frame_cnt1};
   endfunction

   always @(posedge clk) begin
      last_rst = rst;
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_act[d] = 0; m_p[d] = 0; m_fc[d] = 16'd0;
         end else if (!m_act[d]) begin
            if (start) begin
               m_act[d] = 1; m_p[d] = 0; m_pat[d] = pattern_sel;
            end
         end else if (m_p[d] == frame_len(d) - 1) begin
            m_p[d] = 0;
            if (continuous) m_pat[d] = pattern_sel;
            else            m_act[d] = 0;
         end else begin
            m_p[d]++;
            if (m_p[d] == VL + V * line_len(d)) m_fc[d] = m_fc[d] + 16'd1;
         end
      end
   end

   // ---------------- compare process ----------------
   int   ce_cnt  [2] = '{0, 0};
   logic hr_prev [2] = '{1'b0, 1'b0};

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         logic [31:0] a;
         a = dut_out(d);
         check($sformatf("dut%0d_outputs", d), a, model_out(d));
         check($sformatf("dut%0d_nesting", d), {30'd0, a[19] & ~a[20], a[20] & ~a[21]}, 32'd0);
         if (hr_prev[d] && !a[20] && !last_rst)
            check($sformatf("dut%0d_clken_per_line", d), ce_cnt[d], H);
         if (!a[20]) ce_cnt[d] = 0;
         if (a[19])  ce_cnt[d]++;
         hr_prev[d] = a[20];
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic frame_run(input logic [1:0] pat, output int vs_n, output int ce_n,
                            output int done_at, output int idle_at, output int busy1_n,
                            output logic [11:0] ybits, output logic [7:0] ce1_mask);
      int h1;
      vs_n = 0; ce_n = 0; done_at = -1; idle_at = -1; busy1_n = 0;
      ybits = 12'd0; ce1_mask = 8'd0; h1 = 0;
      pattern_sel = pat;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (vif0.per_frame_vsync) vs_n++;
         if (vif0.per_frame_clken) begin
            ce_n++;
            ybits = {ybits[10:0], vif0.per_img_Y};
         end
         if (frame_done0 && done_at < 0) done_at = c;
         if (!busy0 && idle_at < 0)      idle_at = c;
         if (busy1) busy1_n++;
         if (vif1.per_frame_href && h1 < 8) begin
            ce1_mask[h1] = vif1.per_frame_clken;
            h1++;
         end
         tick();
      end
   endtask

   initial begin
      int vs_n, ce_n, done_at, idle_at, busy1_n, n, busy_n, exp_fc;
      logic [11:0] ybits;
      logic [7:0]  ce1_mask;
      bit got;

      do_reset();
      @(negedge clk);
      check("reset_state", dut_out(0), 32'd0);
      tick();

      // pattern 3: full frame timing and border image
      frame_run(2'd3, vs_n, ce_n, done_at, idle_at, busy1_n, ybits, ce1_mask);
      check("vsync_clocks", vs_n, 19);
      check("clken_count", ce_n, 12);
      check("frame_done_cycle", done_at, 20);
      check("busy_low_cycle", idle_at, 23);
      check("div2_frame_len", busy1_n, 34);
      check("div2_clken_slots", {24'd0, ce1_mask}, 32'h55);
      check("border_image", {20'd0, ybits}, 32'hF9F);
      check("frame_cnt_1", {16'd0, frame_cnt0}, 32'd1);

      frame_run(2'd1, vs_n, ce_n, done_at, idle_at, busy1_n, ybits, ce1_mask);
      check("checker_image", {20'd0, ybits}, 32'h5A5);
      check("frame_cnt_2", {16'd0, frame_cnt1}, 32'd2);

      frame_run(2'd0, vs_n, ce_n, done_at, idle_at, busy1_n, ybits, ce1_mask);
      check("zero_image", {20'd0, ybits}, 32'h000);
      check("zero_clken_count", ce_n, 12);

      // reset on the 3rd clken of the first line aborts the frame
      pattern_sel = 2'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0; got = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (vif0.per_frame_clken) n++;
         if (n == 3) begin
            rst = 1'b1;
            got = 1;
            break;
         end
         tick();
      end
      check("rst_trigger_seen", {31'd0, got}, 32'd1);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_abort_outputs", dut_out(0), 32'd0);
      tick();
      frame_run(2'd2, vs_n, ce_n, done_at, idle_at, busy1_n, ybits, ce1_mask);
      check("post_rst_vsync", vs_n, 19);
      check("post_rst_done_cycle", done_at, 20);
      check("post_rst_frame_cnt", {16'd0, frame_cnt0}, 32'd1);

      // continuous: three back-to-back frames, a stray start mid-frame
      do_reset();
      tick();
      continuous = 1'b1;
      pattern_sel = 2'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      busy_n = 0;
      exp_fc = 1;
      for (int c = 1; c <= 66; c++) begin
         @(negedge clk);
         if (busy0) busy_n++;
         if (frame_done0) begin
            check("cont_frame_cnt", {16'd0, frame_cnt0}, exp_fc);
            exp_fc++;
         end
         start = (c == 30);
         tick();
      end
      start = 1'b0;
      continuous = 1'b0;
      check("cont_busy_clocks", busy_n, 66);
      check("cont_frames_seen", exp_fc, 4);
      got = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (!busy0 && !busy1) begin
            got = 1;
            break;
         end
         tick();
      end
      check("cont_stops", {31'd0, got}, 32'd1);
      tick();

      // randomized traffic, checked cycle by cycle against the model
      for (int c = 0; c < 3000; c++) begin
         start       = ($urandom % 6) == 0;
         continuous  = ($urandom % 2) == 1;
         pattern_sel = 2'($urandom % 4);
         rst         = ($urandom % 400) == 0;
         tick();
      end
      rst = 1'b0;
      start = 1'b0;
      continuous = 1'b0;
      for (int c = 0; c < 80; c++) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vip_binary_stream_gen.md
Name: vip_binary_stream_gen

Overview:
- Source end of the 1-bit VIP pixel stream. It generates per_frame_vsync, per_frame_href, per_frame_clken and a 1-bit per_img_Y.
- Provides the exact stream that the 3x3 1-bit matrix generator and the downstream binary morphology blocks consume.
- Drives bench and in-system self-test of the window/line-buffer path, with programmable geometry, blanking, pixel pacing and test patterns.

Parameters:
IMG_HDISP, 10'd480, active pixels per line (>=2)
IMG_VDISP, 10'd272, active lines per frame (>=2)
H_BLANK, 10'd16, clocks of href low after each active line (>=1)
V_LEAD, 10'd4, clocks of vsync high before the first href of a frame (>=1)
V_BLANK, 10'd32, clocks of vsync low after the last line's H_BLANK (>=1)
CLKEN_DIV, 4'd1, clocks per pixel slot (1..15)

Ports:
clk  input  1  pixel clock
rst  input  1  reset
start  input  1  single-cycle request to begin a frame, honoured only in IDLE
continuous  input  1  sampled at the end of V_BLANK: 1 = start the next frame immediately
pattern_sel  input  2  0 all-zero, 1 checkerboard x[0]^y[0], 2 vertical stripes x[3], 3 one-pixel border (x==0|x==H-1|y==0|y==V-1); latched at frame start
per_frame_vsync  output  1  high for the whole frame (lead + all lines incl. H_BLANK)
per_frame_href  output  1  high during active pixel slots of a line
per_frame_clken  output  1  one-clock pixel-valid strobe inside href
per_img_Y  output  1  pixel value, held for the whole slot
busy  output  1  high from the cycle after start is accepted through the last V_BLANK clock
frame_done  output  1  one-cycle pulse on the first V_BLANK clock
frame_cnt  output  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Interface (already decided): one clock, clk. rst is synchronous and active-high.
- Reset outputs: while rst is high, and on the first cycle after, all outputs are 0. State is IDLE; x, y and slot counters are 0; frame_cnt is 0.
- Reset asserted mid-frame aborts immediately. No partial line is completed.
- FSM states: IDLE -> LEAD -> ACTIVE -> HBLK -> (ACTIVE | VBLK) -> (LEAD | IDLE).
- IDLE: outputs low. If start=1 at edge k, then at k+1 the state is LEAD, vsync=1, busy=1, and pattern_sel is latched.
- LEAD: vsync=1, href=0 for V_LEAD clocks, then ACTIVE.
- ACTIVE: href=1 for IMG_HDISP*CLKEN_DIV clocks.
  - x advances once per slot.
  - clken=1 only in the first clock of each slot.
  - per_img_Y = f(pattern, x, y) is registered and stable for the whole slot; it is 0 whenever href=0.
- HBLK: href=0, vsync=1 for H_BLANK clocks.
  - Then y++; if y < IMG_VDISP, go to ACTIVE with x=0.
  - Else go to VBLK with vsync=0.
- VBLK: vsync=0 for V_BLANK clocks.
  - frame_done=1 and frame_cnt++ on the first VBLK clock.
  - On the last VBLK clock: if continuous=1, go to LEAD with pattern re-latched; else go to IDLE with busy=0 on the next cycle.
- start in any state other than IDLE is ignored. No queuing.
- Frame length in clocks = V_LEAD + IMG_VDISP*(IMG_HDISP*CLKEN_DIV + H_BLANK) + V_BLANK.
- clken count per frame = IMG_HDISP*IMG_VDISP exactly. clken is never high outside href, and href is never high outside vsync.
- x and y are 10-bit and compare against IMG_HDISP-1 and IMG_VDISP-1. No overflow is possible within legal parameters.
- continuous is ignored outside the last VBLK clock. Deasserting it mid-frame still completes the current frame.

Test Plan:
- H=4, V=3, H_BLANK=2, V_LEAD=1, V_BLANK=3, DIV=1, start pulse at cycle 0 -> vsync high cycles 1..19 (19 clocks); 3 href pulses of 4 clocks at cycles 2-5, 8-11, 14-17; 12 clkens; frame_done at cycle 20; busy low from cycle 23; frame_cnt=1.
- Same geometry, pattern 3 -> Y sampled on clken rows 1111/1001/1111 (10 ones); pattern 1 -> 0101/1010/0101; pattern 0 -> 12 zeros.
- DIV=2 -> each href is 8 clocks with clken on the 1st, 3rd, 5th and 7th; Y constant across each 2-clock slot; frame length = 1 + 3*(8+2) + 3 = 34 clocks.
- continuous=1 held, 3 frames -> 2nd LEAD starts the clock after the last VBLK clock; frame_cnt 1, 2, 3; a start pulse mid-frame does not alter timing.
- rst=1 asserted at the 3rd clken of line 1 -> next cycle all outputs 0 and frame_cnt=0; a new start produces a full-length, correctly ordered frame.
- Monitor checks on every run -> clken only inside href, href only inside vsync, and clkens per href line = IMG_HDISP.
